// File: rtl/viterbi_feeder_if.sv
// Score stream plus the viterbi_1 control bus, bundled so that one port carries both.
// The slave modport is the feeder side; the master modport is the scorer/viterbi side.
interface viterbi_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        v_start;
  logic        v_write;
  logic [15:0] v_index;
  logic [31:0] v_data;
  logic        v_busy;
  logic        v_dv;
  logic        v_result;

  modport slave (
    input  s_valid, s_data, s_last, v_busy, v_dv, v_result,
    output s_ready, v_start, v_write, v_index, v_data
  );

  modport master (
    output s_valid, s_data, s_last, v_busy, v_dv, v_result,
    input  s_ready, v_start, v_write, v_index, v_data
  );
endinterface

// File: rtl/viterbi_feeder.sv
// Ping-pong buffers score frames and sequences viterbi_1 (LOAD/ARM/RUN/GAP) one frame at a time.
// Reports each decision as a one-cycle pulse; framing and timeout errors are sticky.
module viterbi_feeder #(
  parameter int STATE   = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset,
  viterbi_feeder_if.slave bus,
  output logic            det_valid,
  output logic            det_result,
  output logic [15:0]     frame_cnt,
  output logic            err_frame,
  output logic            err_timeout
);
  localparam int IW = (STATE > 1) ? $clog2(STATE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST  = IW'(STATE - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   bank_q [2][STATE];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          det_valid_q, det_result_q;
  logic [15:0]   frame_cnt_q;
  logic          err_frame_q, err_timeout_q;

  logic          s_ready_w, accept, at_last, frame_done, frame_bad, release_bank;
  logic          det_fire, tmo_fire;
  logic          start_w, write_w;
  logic [15:0]   index_w;
  logic [31:0]   data_w;

  // Input side: a word that disagrees with s_last discards the whole partial frame.
  assign s_ready_w    = !full_q[wr_bank_q];
  assign accept       = bus.s_valid && s_ready_w;
  assign at_last      = (wr_idx_q == LAST);
  assign frame_done   = accept && at_last && bus.s_last;
  assign frame_bad    = accept && (at_last != bus.s_last);
  assign release_bank = (state_q == S_LOAD) && (k_q == LAST);

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q ^ frame_done;
    rd_bank_d = rd_bank_q ^ release_bank;
    wr_idx_d  = wr_idx_q;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    if (frame_done)   full_d[wr_bank_q] = 1'b1;
    if (frame_done || frame_bad) wr_idx_d = '0;
    else if (accept)             wr_idx_d = wr_idx_q + IW'(1);
  end

  // Sequencer. IDLE/GAP look at full_d so a frame completing this cycle loads next cycle.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tmo_d    = tmo_q;
    det_fire = 1'b0;
    tmo_fire = 1'b0;
    start_w  = 1'b0;
    write_w  = 1'b0;
    index_w  = '0;
    data_w   = '0;
    case (state_q)
      S_IDLE: begin
        if (full_d[rd_bank_q] && !bus.v_busy) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        start_w = 1'b1;
        write_w = 1'b1;
        index_w = 16'(k_q);
        data_w  = bank_q[rd_bank_q][k_q];
        if (k_q == LAST) begin
          state_d = S_ARM;
          tmo_d   = '0;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_ARM, S_RUN: begin
        start_w = 1'b1;
        index_w = 16'(STATE - 1);
        tmo_d   = tmo_q + TW'(1);
        if (state_q == S_RUN && bus.v_dv) begin
          det_fire = 1'b1;
          state_d  = S_GAP;
        end else if (tmo_q == TMAX) begin
          tmo_fire = 1'b1;
          state_d  = S_GAP;
        end else if (state_q == S_ARM && bus.v_busy) begin
          state_d = S_RUN;
        end
      end
      S_GAP: begin
        if (full_d[rd_bank_q]) begin
          state_d = S_LOAD;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      k_q           <= '0;
      tmo_q         <= '0;
      det_valid_q   <= 1'b0;
      det_result_q  <= 1'b0;
      frame_cnt_q   <= '0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      k_q           <= k_d;
      tmo_q         <= tmo_d;
      det_valid_q   <= det_fire;
      err_frame_q   <= err_frame_q | frame_bad;
      err_timeout_q <= err_timeout_q | tmo_fire;
      if (det_fire) begin
        det_result_q <= bus.v_result;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Score storage carries no reset; a bank is only read once marked full.
  always_ff @(posedge clk) begin
    if (accept && !frame_bad) bank_q[wr_bank_q][wr_idx_q] <= bus.s_data;
  end

  assign bus.s_ready  = s_ready_w;
  assign bus.v_start  = start_w;
  assign bus.v_write  = write_w;
  assign bus.v_index  = index_w;
  assign bus.v_data   = data_w;
  assign det_valid    = det_valid_q;
  assign det_result   = det_result_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_frame    = err_frame_q;
  assign err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_viterbi_feeder.sv
// Directed bench for viterbi_feeder with a small behavioural viterbi_1 model.
// The model's decision is the LSB of the frame's first score XOR model_inv.
module tb_viterbi_feeder;
  localparam int STATE   = 5;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        det_valid, det_result, err_frame, err_timeout;
  logic [15:0] frame_cnt;

  viterbi_feeder_if bus ();

  viterbi_feeder #(.STATE(STATE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .det_valid   (det_valid),
    .det_result  (det_result),
    .frame_cnt   (frame_cnt),
    .err_frame   (err_frame),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int stalls = 0;

  // viterbi_1 model: busy two cycles into ARM, dv a few cycles later, both cleared by start=0.
  logic       model_en  = 1'b1;
  logic       model_inv = 1'b1;
  logic [7:0] mcnt      = '0;
  logic       mfirst    = 1'b0;
  logic       m_busy    = 1'b0;
  logic       m_dv      = 1'b0;
  logic       m_res     = 1'b0;
  assign bus.v_busy   = m_busy;
  assign bus.v_dv     = m_dv;
  assign bus.v_result = m_res;

  always @(posedge clk) begin
    if (!reset || !bus.v_start || bus.v_write) begin
      mcnt   <= '0;
      m_busy <= 1'b0;
      m_dv   <= 1'b0;
      if (reset && bus.v_start && bus.v_write && bus.v_index == 16'd0) mfirst <= bus.v_data[0];
    end else if (model_en) begin
      mcnt   <= mcnt + 8'd1;
      m_busy <= (mcnt >= 8'd1);
      m_dv   <= (mcnt >= 8'd5);
      m_res  <= mfirst ^ model_inv;
    end
  end

  // Monitor: write log, ARM/RUN cycle count, decision log, v_start low-run lengths.
  logic [15:0] widx_q[$];
  logic [31:0] wdat_q[$];
  logic        det_q[$];
  int          lowrun_q[$];
  int          lowrun  = 0;
  int          arm_cnt = 0;

  always @(negedge clk) begin
    if (bus.v_start && bus.v_write) begin
      widx_q.push_back(bus.v_index);
      wdat_q.push_back(bus.v_data);
    end
    if (bus.v_start && !bus.v_write) arm_cnt <= arm_cnt + 1;
    if (det_valid) det_q.push_back(det_result);
    if (!bus.v_start) lowrun <= lowrun + 1;
    else begin
      if (lowrun != 0) lowrun_q.push_back(lowrun);
      lowrun <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && t < 500) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (t >= 500) chk("send_timeout", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int k = 0; k < STATE; k++) send(base + 32'(k), k == STATE - 1);
  endtask

  task automatic wait_det(input string tag);
    int t = 0;
    while (!det_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(det_valid), 32'd1);
  endtask

  initial begin
    int w0, d0, a0;
    logic [31:0] base3 [3];
    logic        res3  [3];
    base3[0] = 32'd101; base3[1] = 32'd200; base3[2] = 32'd301;
    res3[0]  = 1'b1;    res3[1]  = 1'b0;    res3[2]  = 1'b1;

    reset       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_v_bus", {bus.v_start, bus.v_write, bus.v_index, 14'd0}, 32'd0);
    chk("rst_v_data", bus.v_data, 32'd0);
    chk("rst_status", {det_valid, det_result, err_frame, err_timeout, 12'd0, frame_cnt}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single frame 10..50, decision 1
    w0 = widx_q.size();
    send(32'd10, 1'b0); send(32'd20, 1'b0); send(32'd30, 1'b0);
    send(32'd40, 1'b0); send(32'd50, 1'b1);
    chk("t1_lat_write", 32'(bus.v_write), 32'd1);
    chk("t1_lat_index", 32'(bus.v_index), 32'd0);
    chk("t1_lat_data", bus.v_data, 32'd10);
    wait_det("t1_det_seen");
    chk("t1_det_result", 32'(det_result), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_gap_start", 32'(bus.v_start), 32'd0);
    @(negedge clk);
    chk("t1_pulse_len", 32'(det_valid), 32'd0);
    chk("t1_nwrites", 32'(widx_q.size() - w0), 32'd5);
    for (int k = 0; k < STATE; k++) begin
      chk("t1_w_index", 32'(widx_q[w0 + k]), 32'(k));
      chk("t1_w_data", wdat_q[w0 + k], 32'(10 * (k + 1)));
    end

    // Three back-to-back frames
    model_inv = 1'b0;
    w0 = widx_q.size();
    a0 = stalls;
    for (int f = 0; f < 3; f++) send_frame(base3[f]);
    chk("t2_ready_drop", 32'(bus.s_ready), 32'd0);
    chk("t2_no_stall", 32'(stalls - a0), 32'd0);
    for (int f = 0; f < 3; f++) begin
      wait_det("t2_det_seen");
      chk("t2_det_order", 32'(det_result), 32'(res3[f]));
      @(negedge clk);
    end
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("t2_gap_run_a", 32'(lowrun_q[lowrun_q.size() - 1]), 32'd1);
    chk("t2_gap_run_b", 32'(lowrun_q[lowrun_q.size() - 2]), 32'd1);
    chk("t2_nwrites", 32'(widx_q.size() - w0), 32'd15);
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < STATE; k++) begin
        chk("t2_w_index", 32'(widx_q[w0 + f * STATE + k]), 32'(k));
        chk("t2_w_data", wdat_q[w0 + f * STATE + k], base3[f] + 32'(k));
      end

    // Early s_last, then a clean frame
    chk("t3_err_before", 32'(err_frame), 32'd0);
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    chk("t3_err_frame", 32'(err_frame), 32'd1);
    chk("t3_no_load", 32'(bus.v_start), 32'd0);
    w0 = widx_q.size();
    send_frame(32'd7);
    wait_det("t3_det_seen");
    chk("t3_det_result", 32'(det_result), 32'd1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("t3_first_data", wdat_q[w0], 32'd7);
    chk("t3_last_data", wdat_q[w0 + STATE - 1], 32'd11);
    chk("t3_err_sticky", 32'(err_frame), 32'd1);
    @(negedge clk);

    // Timeout: model never goes busy
    model_en = 1'b0;
    a0 = arm_cnt;
    d0 = det_q.size();
    send_frame(32'd20);
    for (int t = 0; t < 300 && !err_timeout; t++) @(negedge clk);
    chk("t4_err_timeout", 32'(err_timeout), 32'd1);
    chk("t4_gap_start", 32'(bus.v_start), 32'd0);
    chk("t4_armrun_cycles", 32'(arm_cnt - a0), 32'(TIMEOUT));
    @(negedge clk);
    chk("t4_no_det", 32'(det_q.size() - d0), 32'd0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd5);
    model_en = 1'b1;

    // Reset during RUN
    send_frame(32'd30);
    for (int t = 0; t < 100 && !bus.v_busy; t++) @(negedge clk);
    chk("t5_busy_seen", 32'(bus.v_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_v_start", 32'(bus.v_start), 32'd0);
    chk("t5_s_ready", 32'(bus.s_ready), 32'd1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_errors", {30'd0, err_frame, err_timeout}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    send_frame(32'd40);
    wait_det("t6_det_a");
    chk("t6_cnt_ffff", 32'(frame_cnt), 32'h0000_FFFF);
    @(negedge clk);
    send_frame(32'd50);
    wait_det("t6_det_b");
    chk("t6_cnt_wrap", 32'(frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
